// File: rtl/axi_lite_pkg.sv
// Shared response codes and controller state encoding for the AXI4-Lite register bus controller.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACCESS,
    WR_RESP,
    RD_ACCESS,
    RD_RESP
  } ctrl_state_t;

endpackage

// File: rtl/axi_lite_capture_buffer.sv
// One-entry capture register for an AXI channel; holds a beat until the owning response completes.
module axi_lite_capture_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  input  logic             free_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Handshake: a beat transfers on valid_i && ready_o; ready_o is low while the
  // entry is held and while in reset, and free_i releases the entry.
  assign ready_o = rst_ni & ~full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (valid_i && ready_o) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (free_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/axi_lite_register_bus_controller.sv
// AXI4-Lite slave that turns AW/W/AR traffic into single req/ack register accesses with
// round-robin read/write arbitration, range decode and a bounded wait for reg_ack.
module axi_lite_register_bus_controller
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned REG_INDEX_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [REG_INDEX_WIDTH-1:0]   reg_index,
  output logic                         reg_wr_en,
  output logic                         reg_rd_en,
  output logic [DATA_WIDTH-1:0]        reg_wdata,
  output logic [DATA_WIDTH/8-1:0]      reg_wstrb,
  input  logic [DATA_WIDTH-1:0]        reg_rdata,
  input  logic                         reg_ack,
  input  logic                         reg_err,
  output ctrl_state_t                  dbg_state_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_HI = REG_INDEX_WIDTH + 1;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t              state_q, state_d;
  logic                     wr_first_q, wr_first_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [1:0]               resp_q, resp_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

  logic                     aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0]    aw_addr, ar_addr;
  logic [STRB_W+DATA_WIDTH-1:0] w_beat;
  logic                     wr_free, rd_free;
  logic                     aw_hs, w_hs, ar_hs;
  logic                     wr_elig, rd_elig, wr_oor, rd_oor;
  logic                     unused_bits;

  axi_lite_capture_buffer #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
    .clk_i(S_AXI_ACLK), .rst_ni(S_AXI_ARESETN), .valid_i(S_AXI_AWVALID), .data_i(S_AXI_AWADDR),
    .ready_o(S_AXI_AWREADY), .free_i(wr_free), .full_o(aw_full), .data_o(aw_addr)
  );

  axi_lite_capture_buffer #(.WIDTH(STRB_W + DATA_WIDTH)) u_w_buf (
    .clk_i(S_AXI_ACLK), .rst_ni(S_AXI_ARESETN), .valid_i(S_AXI_WVALID),
    .data_i({S_AXI_WSTRB, S_AXI_WDATA}), .ready_o(S_AXI_WREADY), .free_i(wr_free),
    .full_o(w_full), .data_o(w_beat)
  );

  axi_lite_capture_buffer #(.WIDTH(ADDR_WIDTH)) u_ar_buf (
    .clk_i(S_AXI_ACLK), .rst_ni(S_AXI_ARESETN), .valid_i(S_AXI_ARVALID), .data_i(S_AXI_ARADDR),
    .ready_o(S_AXI_ARREADY), .free_i(rd_free), .full_o(ar_full), .data_o(ar_addr)
  );

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // Beats handshaking this cycle count as eligible so a grant lands the same cycle they arrive.
  assign wr_elig = (aw_full | aw_hs) & (w_full | w_hs);
  assign rd_elig = ar_full | ar_hs;
  assign wr_oor  = aw_full ? |aw_addr[ADDR_WIDTH-1:IDX_HI+1] : |S_AXI_AWADDR[ADDR_WIDTH-1:IDX_HI+1];
  assign rd_oor  = ar_full ? |ar_addr[ADDR_WIDTH-1:IDX_HI+1] : |S_AXI_ARADDR[ADDR_WIDTH-1:IDX_HI+1];

  assign reg_wr_en    = (state_q == WR_ACCESS);
  assign reg_rd_en    = (state_q == RD_ACCESS);
  assign reg_index    = reg_wr_en ? aw_addr[IDX_HI:2] : (reg_rd_en ? ar_addr[IDX_HI:2] : '0);
  assign reg_wdata    = reg_wr_en ? w_beat[DATA_WIDTH-1:0] : '0;
  assign reg_wstrb    = reg_wr_en ? w_beat[STRB_W+DATA_WIDTH-1:DATA_WIDTH] : '0;

  assign S_AXI_BVALID = (state_q == WR_RESP);
  assign S_AXI_BRESP  = S_AXI_BVALID ? resp_q : RESP_OKAY;
  assign S_AXI_RVALID = (state_q == RD_RESP);
  assign S_AXI_RRESP  = S_AXI_RVALID ? resp_q : RESP_OKAY;
  assign S_AXI_RDATA  = S_AXI_RVALID ? rdata_q : '0;
  assign wr_free      = S_AXI_BVALID & S_AXI_BREADY;
  assign rd_free      = S_AXI_RVALID & S_AXI_RREADY;
  assign dbg_state_o  = state_q;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr[1:0], ar_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    wr_first_d = wr_first_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wr_elig && (!rd_elig || wr_first_q)) begin
          if (rd_elig) wr_first_d = 1'b0;
          if (wr_oor) begin
            state_d = WR_RESP;
            resp_d  = RESP_DECERR;
          end else begin
            state_d = WR_ACCESS;
          end
        end else if (rd_elig) begin
          if (wr_elig) wr_first_d = 1'b1;
          if (rd_oor) begin
            state_d = RD_RESP;
            resp_d  = RESP_DECERR;
            rdata_d = '0;
          end else begin
            state_d = RD_ACCESS;
          end
        end
      end
      WR_ACCESS: begin
        if (reg_ack) begin
          state_d = WR_RESP;
          resp_d  = reg_err ? RESP_SLVERR : RESP_OKAY;
        end else if (cnt_q == CNT_LAST) begin
          state_d = WR_RESP;
          resp_d  = RESP_SLVERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_ACCESS: begin
        if (reg_ack) begin
          state_d = RD_RESP;
          resp_d  = reg_err ? RESP_SLVERR : RESP_OKAY;
          rdata_d = reg_err ? '0 : reg_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RD_RESP;
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_RESP: if (S_AXI_BREADY) state_d = IDLE;
      RD_RESP: if (S_AXI_RREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      wr_first_q <= 1'b1;
      cnt_q      <= '0;
      resp_q     <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_first_q <= wr_first_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_register_bus_controller.sv
// Directed bench: drivers push expected B/R responses and register requests into queues,
// monitors pop and compare as the DUT presents them.
module tb_axi_lite_register_bus_controller;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] S_AXI_AWADDR = '0, S_AXI_WDATA = '0, S_AXI_ARADDR = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_ARVALID = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA, reg_wdata;
  logic [7:0]  reg_index;
  logic        reg_wr_en, reg_rd_en;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_rdata = '0;
  logic        reg_ack = 1'b0, reg_err = 1'b0;
  ctrl_state_t dbg_state;

  int checks = 0, failures = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [44:0] exp_req_q[$];

  int          ack_delay = 0;
  logic        ack_err = 1'b0, ack_hold = 1'b0, late_ack_req = 1'b0;
  logic [31:0] ack_data = '0;
  int          wait_cnt = 0, rd_en_cycles = 0, wr_pulses = 0;
  logic        prev_wr = 1'b0;

  always #5 clk = ~clk;

  axi_lite_register_bus_controller #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_INDEX_WIDTH(8), .TIMEOUT_CYCLES(255)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(bready), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(rready), .reg_index(reg_index), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .reg_err(reg_err), .dbg_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the expected queue whenever a B or R handshake is about to happen.
  always @(negedge clk) begin
    if (reg_wr_en || reg_rd_en) check("en_exclusive", {reg_wr_en, reg_rd_en} == 2'b11, 0);
    if (reg_wr_en && !prev_wr) wr_pulses++;
    prev_wr = reg_wr_en;
    if (S_AXI_BVALID && bready) begin
      if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
      else check("bresp", S_AXI_BRESP, exp_b_q.pop_front());
    end
    if (S_AXI_RVALID && rready) begin
      if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
      else check("rresp_rdata", {S_AXI_RRESP, S_AXI_RDATA}, exp_r_q.pop_front());
    end
  end

  // Register target model: checks each new request, then acks after ack_delay wait cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
      if (!rst_n) begin
        wait_cnt = 0;
      end else if (reg_wr_en || reg_rd_en) begin
        if (reg_rd_en) rd_en_cycles++;
        if (wait_cnt == 0) begin
          if (exp_req_q.size() == 0) check("req_unexpected", 1, 0);
          else check("req", {reg_wr_en, reg_index, reg_wdata, reg_wstrb}, exp_req_q.pop_front());
        end
        if (!ack_hold && wait_cnt == ack_delay) begin
          reg_ack = 1'b1; reg_err = ack_err; reg_rdata = ack_data; wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (late_ack_req) begin
          reg_ack = 1'b1; reg_rdata = 32'hBAD0_BAD0; late_ack_req = 1'b0;
        end
      end
    end
  end

  task automatic issue(input bit do_aw, input logic [31:0] awa, input bit do_w,
                       input logic [31:0] wd, input logic [3:0] ws, input bit do_ar,
                       input logic [31:0] ara);
    bit pa, pw, pr, ha, hw, hr;
    pa = do_aw; pw = do_w; pr = do_ar;
    S_AXI_AWADDR = awa; S_AXI_WDATA = wd; S_AXI_WSTRB = ws; S_AXI_ARADDR = ara;
    S_AXI_AWVALID = pa; S_AXI_WVALID = pw; S_AXI_ARVALID = pr;
    for (int i = 0; i < 50 && (pa || pw || pr); i++) begin
      @(negedge clk);
      ha = pa && S_AXI_AWREADY; hw = pw && S_AXI_WREADY; hr = pr && S_AXI_ARREADY;
      @(posedge clk); #1;
      if (ha) begin pa = 0; S_AXI_AWVALID = 1'b0; end
      if (hw) begin pw = 0; S_AXI_WVALID = 1'b0; end
      if (hr) begin pr = 0; S_AXI_ARVALID = 1'b0; end
    end
    if (pa || pw || pr) begin
      check("issue_timeout", 1, 0);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_b_q.size() == 0 && exp_r_q.size() == 0 && exp_req_q.size() == 0 &&
          dbg_state == IDLE) break;
      cycles(1);
    end
    if (i == budget) check("wait_done_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
                          S_AXI_RRESP, S_AXI_RVALID, reg_wr_en, reg_rd_en, reg_index, reg_wstrb}, 0);
    check({tag, "_rdata"}, S_AXI_RDATA, 0);
    check({tag, "_wdata"}, reg_wdata, 0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    cycles(2);
    check_reset_outputs("in_reset");
    exp_b_q.delete(); exp_r_q.delete(); exp_req_q.delete();
    rst_n = 1'b1;
    cycles(1);
    check("ready_after_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    check("state_after_reset", dbg_state, IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses0, i;
    reset_dut();

    // W before AW, immediate ack
    exp_req_q.push_back({1'b1, 8'd4, 32'hA5A5_0001, 4'hF});
    exp_b_q.push_back(RESP_OKAY);
    pulses0 = wr_pulses;
    issue(0, 0, 1, 32'hA5A5_0001, 4'hF, 0, 0);
    check("wready_held", S_AXI_WREADY, 0);
    cycles(1);
    issue(1, 32'h0000_0010, 0, 0, 0, 0, 0);
    check("awwready_low_in_access", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
    for (i = 0; i < 20 && !S_AXI_BVALID; i++) cycles(1);
    check("awwready_low_in_resp", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
    wait_done(20);
    check("awwready_after_b", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    check("one_wr_pulse", wr_pulses - pulses0, 1);

    // Top-of-range read with 3 wait cycles and RREADY back-pressure
    ack_delay = 3; ack_data = 32'h1234_5678; rready = 1'b0;
    exp_req_q.push_back({1'b0, 8'd255, 32'h0, 4'h0});
    exp_r_q.push_back({RESP_OKAY, 32'h1234_5678});
    issue(0, 0, 0, 0, 0, 1, 32'h0000_03FC);
    check("arready_low", S_AXI_ARREADY, 0);
    for (i = 0; i < 20 && !S_AXI_RVALID; i++) cycles(1);
    cycles(1);
    check("rvalid_hold1", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, 32'h1234_5678});
    cycles(1);
    check("rvalid_hold2", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, RESP_OKAY, 32'h1234_5678});
    rready = 1'b1;
    wait_done(20);
    ack_delay = 0;

    // Simultaneous read/write pairs from reset: write, read, then read, write
    reset_dut();
    ack_data = 32'hCAFE_0004;
    exp_req_q.push_back({1'b1, 8'd2, 32'h1111_2222, 4'hF});
    exp_req_q.push_back({1'b0, 8'd1, 32'h0, 4'h0});
    exp_b_q.push_back(RESP_OKAY);
    exp_r_q.push_back({RESP_OKAY, 32'hCAFE_0004});
    issue(1, 32'h0000_0008, 1, 32'h1111_2222, 4'hF, 1, 32'h0000_0004);
    wait_done(40);
    exp_req_q.push_back({1'b0, 8'd1, 32'h0, 4'h0});
    exp_req_q.push_back({1'b1, 8'd2, 32'h3333_4444, 4'h5});
    exp_b_q.push_back(RESP_OKAY);
    exp_r_q.push_back({RESP_OKAY, 32'hCAFE_0004});
    issue(1, 32'h0000_0008, 1, 32'h3333_4444, 4'h5, 1, 32'h0000_0004);
    wait_done(40);

    // Out-of-range write and read, then target error on a read
    pulses0 = wr_pulses; rd_en_cycles = 0;
    exp_b_q.push_back(RESP_DECERR);
    issue(1, 32'h0000_0400, 1, 32'hFFFF_FFFF, 4'hF, 0, 0);
    wait_done(20);
    check("decerr_no_wr", wr_pulses - pulses0, 0);
    exp_r_q.push_back({RESP_DECERR, 32'h0});
    issue(0, 0, 0, 0, 0, 1, 32'h8000_0000);
    wait_done(20);
    check("decerr_no_rd", rd_en_cycles, 0);
    ack_err = 1'b1; ack_data = 32'hDEAD_BEEF;
    exp_req_q.push_back({1'b0, 8'd3, 32'h0, 4'h0});
    exp_r_q.push_back({RESP_SLVERR, 32'h0});
    issue(0, 0, 0, 0, 0, 1, 32'h0000_000C);
    wait_done(20);
    ack_err = 1'b0;

    // Timeout after 255 request cycles, then a stray ack while idle
    ack_hold = 1'b1; rd_en_cycles = 0;
    exp_req_q.push_back({1'b0, 8'd8, 32'h0, 4'h0});
    exp_r_q.push_back({RESP_SLVERR, 32'h0});
    issue(0, 0, 0, 0, 0, 1, 32'h0000_0020);
    wait_done(400);
    check("timeout_len", rd_en_cycles, 255);
    ack_hold = 1'b0; late_ack_req = 1'b1;
    cycles(3);
    check("late_ack_ignored", {S_AXI_BVALID, S_AXI_RVALID, reg_rd_en, reg_wr_en}, 0);
    check("late_ack_state", dbg_state, IDLE);
    ack_data = 32'h0BAD_F00D;
    exp_req_q.push_back({1'b0, 8'd9, 32'h0, 4'h0});
    exp_r_q.push_back({RESP_OKAY, 32'h0BAD_F00D});
    issue(0, 0, 0, 0, 0, 1, 32'h0000_0024);
    wait_done(20);

    // Asynchronous reset in the middle of a read access
    ack_hold = 1'b1;
    exp_req_q.push_back({1'b0, 8'd5, 32'h0, 4'h0});
    issue(0, 0, 0, 0, 0, 1, 32'h0000_0014);
    for (i = 0; i < 20 && !reg_rd_en; i++) cycles(1);
    cycles(2);
    check("rd_access_before_reset", {reg_rd_en, reg_index}, {1'b1, 8'd5});
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_b_q.delete(); exp_r_q.delete(); exp_req_q.delete();
    cycles(3);
    rst_n = 1'b1; ack_hold = 1'b0;
    cycles(1);
    check("ready_after_async_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    exp_req_q.push_back({1'b1, 8'd4, 32'h5A5A_5A5A, 4'h3});
    exp_b_q.push_back(RESP_OKAY);
    issue(1, 32'h0000_0010, 1, 32'h5A5A_5A5A, 4'h3, 0, 0);
    wait_done(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_register_bus_controller.md
Name: axi_lite_register_bus_controller

Overview:
- AXI4-Lite slave front end for the processing element test system.
- Accepts the PS M00_AXI master's five channels and converts them into a simple request/acknowledge register bus that drives PE configuration and status registers.
- Arbitrates between pending reads and writes.
- Decodes the address range and bounds every register access with a timeout, so a hung target cannot stall the PS interconnect.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI and register bus data width. Must be 32.
- REG_INDEX_WIDTH, 8, width of the word index. Register space is 2^REG_INDEX_WIDTH words.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for reg_ack before returning an error. Must be at least 1.

Ports:
- S_AXI_ACLK  in  1  clock, positive-edge triggered
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read valid
- S_AXI_RREADY  in  1  read ready
- reg_index  out  REG_INDEX_WIDTH  word index of the current access
- reg_wr_en  out  1  write request, level
- reg_rd_en  out  1  read request, level
- reg_wdata  out  DATA_WIDTH  write data
- reg_wstrb  out  DATA_WIDTH/8  byte strobes
- reg_rdata  in  DATA_WIDTH  read data, valid when reg_ack is high
- reg_ack  in  1  one-cycle completion
- reg_err  in  1  target error, sampled with reg_ack

Behaviour:
- Reset: asynchronous on S_AXI_ARESETN low. Behaviour while in reset:
  - All outputs are 0, except AWREADY, WREADY and ARREADY, which are 1 once reset deasserts.
  - State returns to IDLE and all buffers empty.
  - The write-priority flag resets to "write first".
  - Any access in flight is dropped with no response; the master is reset with the fabric.
- Capture buffers: three one-entry buffers for AW, W and AR.
  - AWREADY = !aw_full, WREADY = !w_full, ARREADY = !ar_full.
  - A buffer fills on VALID&&READY and empties only on completion of its response handshake: BVALID&&BREADY for AW and W, RVALID&&RREADY for AR.
  - AW and W may arrive in either order or in the same cycle.
- Address decode:
  - reg_index = addr[REG_INDEX_WIDTH+1:2]; addr[1:0] is ignored.
  - If any addr bit above REG_INDEX_WIDTH+1 is nonzero, the access is out of range. No reg_* request is issued, and the response is DECERR (2'b11) one cycle after arbitration. RDATA = 0.
- FSM states: IDLE, WR_ACCESS, WR_RESP, RD_ACCESS, RD_RESP.
  - IDLE:
    - Write eligible means aw_full && w_full.
    - Read eligible means ar_full.
    - If both are eligible, the priority flag decides, and the flag toggles after each grant (round-robin).
    - If only one is eligible, it is taken; the flag is unchanged.
  - WR_ACCESS / RD_ACCESS:
    - reg_wr_en / reg_rd_en are held high, with reg_index, reg_wdata and reg_wstrb stable, until reg_ack or timeout.
    - On reg_ack: response = reg_err ? SLVERR (2'b10) : OKAY (2'b00). On a read, RDATA latches reg_rdata (0 on error).
    - Timeout counter resets to 0 on entry. If TIMEOUT_CYCLES cycles elapse without ack, the FSM drops the request and responds SLVERR with RDATA = 0.
    - A reg_ack arriving later, in IDLE, is ignored.
  - WR_RESP / RD_RESP:
    - BVALID / RVALID are high, and BRESP / RDATA / RRESP are stable, until BREADY / RREADY.
    - Then the corresponding buffers free and the FSM goes to IDLE.
- Latency: AW+W accepted in cycle 0 → reg_wr_en high in cycle 1 → reg_ack in cycle 1 → BVALID in cycle 2. Reads have the same timing.
- Only one register access is outstanding at a time; reg_wr_en and reg_rd_en are never both high.
- A new AW/W/AR may be captured while the other channel's access is in progress.

Decomposition:
- Package axi_lite_pkg contains:
  - Response constants RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - Enum typedef ctrl_state_t for the five states.
- Sub-module axi_lite_capture_buffer: parameterised by width, one-entry valid/ready register with a free input. Instantiated three times, for AW, W and AR.

Test Plan:
- Write with W before AW: WDATA=0xA5A5_0001 at cycle 0, AWADDR=0x0000_0010 at cycle 2, ack at the first request cycle → reg_index=4, reg_wstrb=0xF, one reg_wr_en pulse, BRESP=OKAY, AWREADY/WREADY low until B handshake.
- Read 0x0000_03FC, reg_rdata=0x1234_5678 acked after 3 wait cycles → reg_index=255, RDATA=0x1234_5678, RRESP=OKAY, RVALID held across 2 cycles of RREADY low.
- Simultaneous read 0x4 and write 0x8, repeated twice from reset → write granted first, then read, then read first on the second pair; never both enables high.
- Write to 0x0000_0400 → no reg_wr_en, BRESP=DECERR. Read with reg_err=1 → RRESP=SLVERR, RDATA=0.
- No reg_ack for TIMEOUT_CYCLES=255 → RVALID with RRESP=SLVERR; a late reg_ack is ignored.
- Assert reset during RD_ACCESS → all outputs return to reset values immediately (asynchronously); after release, a new write completes normally.
